// File: rtl/makestuff_ram_stream_pkg.sv
// Shared types for the RAM row-to-span stream reader.
package makestuff_ram_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD,
    S_SEND
  } state_e;

endpackage

// File: rtl/makestuff_ram_stream_reader.sv
// Reads a run of rows from a registered-output RAM and streams each row out as
// NUM_SPANS beats of SPAN_NBITS, span 0 first, with no bubbles between rows.
module makestuff_ram_stream_reader
  import makestuff_ram_stream_pkg::*;
#(
  parameter int ADDR_NBITS = 5,
  parameter int SPAN_NBITS = 8,
  parameter int NUM_SPANS  = 8
) (
  input  logic                            clk_in,
  input  logic                            rstn_in,
  input  logic [ADDR_NBITS-1:0]           cmdAddr_in,
  input  logic [ADDR_NBITS:0]             cmdCount_in,
  input  logic                            cmdValid_in,
  output logic                            cmdReady_out,
  output logic [ADDR_NBITS-1:0]           rdAddr_out,
  input  logic [NUM_SPANS*SPAN_NBITS-1:0] rdData_in,
  output logic [SPAN_NBITS-1:0]           outData_out,
  output logic                            outValid_out,
  input  logic                            outReady_in,
  output logic                            outLast_out
);

  localparam int IDX_NBITS = (NUM_SPANS > 1) ? $clog2(NUM_SPANS) : 1;
  localparam int ROW_NBITS = NUM_SPANS * SPAN_NBITS;

  state_e                  state_q, state_d;
  logic [ADDR_NBITS-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_NBITS:0]     count_q, count_d;
  logic [IDX_NBITS-1:0]    idx_q, idx_d;
  logic [ROW_NBITS-1:0]    row_q, row_d;

  logic last_span;
  logic final_row;
  logic beat_taken;

  assign last_span  = (idx_q == IDX_NBITS'(NUM_SPANS - 1));
  assign final_row  = (count_q == (ADDR_NBITS + 1)'(1));
  assign beat_taken = outValid_out && outReady_in;

  // Outputs are pure functions of registered state, so they cannot change while stalled.
  assign cmdReady_out = (state_q == S_IDLE);
  assign outValid_out = (state_q == S_SEND);
  assign outLast_out  = outValid_out && last_span && final_row;
  assign outData_out  = row_q[int'(idx_q) * SPAN_NBITS +: SPAN_NBITS];
  assign rdAddr_out   = rd_addr_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    count_d   = count_q;
    idx_d     = idx_q;
    row_d     = row_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmdValid_in && cmdCount_in != '0) begin
          rd_addr_d = cmdAddr_in;
          count_d   = cmdCount_in;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_LOAD;
      S_LOAD: begin
        row_d     = rdData_in;
        idx_d     = '0;
        rd_addr_d = rd_addr_q + ADDR_NBITS'(1);
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (beat_taken) begin
          if (!last_span) begin
            idx_d = idx_q + IDX_NBITS'(1);
          end else if (final_row) begin
            idx_d   = '0;
            count_d = '0;
            state_d = S_IDLE;
          end else begin
            // The RAM has been presenting the next row since the previous row load.
            row_d     = rdData_in;
            idx_d     = '0;
            count_d   = count_q - (ADDR_NBITS + 1)'(1);
            rd_addr_d = rd_addr_q + ADDR_NBITS'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the row register is a plain flop bank, reset so outData_out reads zero out of reset.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      row_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
    end
  end

endmodule

// File: tb/tb_makestuff_ram_stream_reader.sv
// Scoreboard bench: directed commands push expected beats; a negedge monitor pops and compares.
module tb_makestuff_ram_stream_reader;

  localparam int ADDR_NBITS = 5;
  localparam int SPAN_NBITS = 8;
  localparam int NUM_SPANS  = 8;
  localparam int NUM_ROWS   = 1 << ADDR_NBITS;

  typedef struct {
    logic [SPAN_NBITS-1:0] data;
    logic                  last;
  } beat_t;

  logic                            clk = 1'b0;
  logic                            rstn = 1'b0;
  logic [ADDR_NBITS-1:0]           cmd_addr = '0;
  logic [ADDR_NBITS:0]             cmd_count = '0;
  logic                            cmd_valid = 1'b0;
  logic                            cmd_ready;
  logic [ADDR_NBITS-1:0]           rd_addr;
  logic [NUM_SPANS*SPAN_NBITS-1:0] rd_data;
  logic [SPAN_NBITS-1:0]           out_data;
  logic                            out_valid;
  logic                            out_ready = 1'b1;
  logic                            out_last;

  logic [NUM_SPANS*SPAN_NBITS-1:0] mem [NUM_ROWS];

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    beats    = 0;
  bit    rand_mode = 1'b0;

  bit                    stall_prev = 1'b0;
  logic [SPAN_NBITS-1:0] prev_data;
  logic                  prev_last;

  always #5 clk = ~clk;

  makestuff_ram_stream_reader #(
    .ADDR_NBITS(ADDR_NBITS),
    .SPAN_NBITS(SPAN_NBITS),
    .NUM_SPANS (NUM_SPANS)
  ) dut (
    .clk_in      (clk),
    .rstn_in     (rstn),
    .cmdAddr_in  (cmd_addr),
    .cmdCount_in (cmd_count),
    .cmdValid_in (cmd_valid),
    .cmdReady_out(cmd_ready),
    .rdAddr_out  (rd_addr),
    .rdData_in   (rd_data),
    .outData_out (out_data),
    .outValid_out(out_valid),
    .outReady_in (out_ready),
    .outLast_out (out_last)
  );

  // Registered-output RAM: row r holds span i = 8r+i (mod 256).
  initial begin
    for (int r = 0; r < NUM_ROWS; r++)
      for (int i = 0; i < NUM_SPANS; i++)
        mem[r][i*SPAN_NBITS +: SPAN_NBITS] = SPAN_NBITS'(NUM_SPANS * r + i);
  end
  always @(posedge clk) rd_data <= mem[rd_addr];

  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = ($urandom_range(99) >= 30);
    else           out_ready = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each handshaken beat against the scoreboard; stalled beats must hold.
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e.data));
          check("beat_last", 32'(out_last), 32'(e.last));
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic push_rows(input int a, input int n);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < NUM_SPANS; i++) begin
        beat_t b;
        b.data = SPAN_NBITS'(NUM_SPANS * ((a + r) % NUM_ROWS) + i);
        b.last = (r == n - 1) && (i == NUM_SPANS - 1);
        exp_q.push_back(b);
      end
  endtask

  // Called at posedge+1; returns at the posedge+1 after acceptance.
  task automatic issue(input int a, input int n);
    int t = 0;
    while (!cmd_ready && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 2000) check("cmd_ready_timeout", 32'd0, 32'd1);
    push_rows(a, n);
    cmd_addr  = ADDR_NBITS'(a);
    cmd_count = (ADDR_NBITS + 1)'(n);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && t < budget) begin
      @(posedge clk); #1; t++;
    end
    check("idle_timeout", 32'(t < budget), 32'd1);
  endtask

  initial begin
    int n;
    int base;

    #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Single row with exact latency and ready timing.
    issue(3, 1);
    check("busy_after_accept", 32'(cmd_ready), 32'd0);
    check("issue_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("load_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("first_beat_valid", 32'(out_valid), 32'd1);
    check("first_beat_data", 32'(out_data), 32'h18);
    repeat (7) @(posedge clk);
    #1;
    check("last_beat_data", 32'(out_data), 32'h1F);
    check("last_beat_flag", 32'(out_last), 32'd1);
    check("last_beat_busy", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_last", 32'(cmd_ready), 32'd1);
    check("valid_after_last", 32'(out_valid), 32'd0);
    wait_idle(10);

    // Multi-row throughput: 32 beats with no gaps.
    issue(0, 4);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    n = 0;
    while (out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("gapless_beats", 32'(n), 32'd32);
    wait_idle(20);

    // Address wrap.
    issue(31, 2);
    wait_idle(100);

    // Backpressure at 30% not-ready.
    rand_mode = 1'b1;
    issue(5, 2);
    wait_idle(2000);
    rand_mode = 1'b0;

    // Zero count: accepted, no output.
    issue(0, 0);
    n = 0;
    repeat (6) begin
      n += int'(!cmd_ready) + int'(out_valid);
      @(posedge clk); #1;
    end
    check("zero_count_quiet", 32'(n), 32'd0);

    // Full RAM from row 10, with commands pulsed mid-stream.
    issue(10, 32);
    repeat (50) @(posedge clk);
    #1;
    check("busy_mid_stream", 32'(cmd_ready), 32'd0);
    cmd_addr  = '0;
    cmd_count = (ADDR_NBITS + 1)'(1);
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle(1000);
    repeat (10) @(posedge clk);
    #1;
    check("no_queued_cmd", 32'(out_valid), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream, then a fresh command.
    base = beats;
    issue(0, 3);
    n = 0;
    while (beats < base + 5 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("reach_beat5", 32'(beats - base), 32'd5);
    rstn = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    issue(1, 1);
    wait_idle(50);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
